// File: rtl/pushbox_pkg.sv
// Shared Pushbox types: move command encoding, key bit positions and arbiter states.
package pushbox_pkg;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_UP      = 3'd1,
        CMD_DOWN    = 3'd2,
        CMD_LEFT    = 3'd3,
        CMD_RIGHT   = 3'd4,
        CMD_RESTART = 3'd5
    } cmd_t;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_VALID = 1'b1
    } arb_state_t;

    localparam int         NUM_KEYS    = 5;
    localparam logic [2:0] KEY_RESTART = 3'd4;
    localparam logic [2:0] KEY_UP      = 3'd3;
    localparam logic [2:0] KEY_DOWN    = 3'd2;
    localparam logic [2:0] KEY_LEFT    = 3'd1;
    localparam logic [2:0] KEY_RIGHT   = 3'd0;

    function automatic cmd_t key_to_cmd(input logic [2:0] key_idx);
        cmd_t c;
        case (key_idx)
            KEY_RESTART: c = CMD_RESTART;
            KEY_UP:      c = CMD_UP;
            KEY_DOWN:    c = CMD_DOWN;
            KEY_LEFT:    c = CMD_LEFT;
            KEY_RIGHT:   c = CMD_RIGHT;
            default:     c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser, debounce, press pulse and optional hold-to-repeat pulses.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press,
    output logic rpt
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam bit RPT_ON   = REPEAT_EN && (REPEAT_PERIOD != 0);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic              sync1_r;
    logic              sync2_r;
    logic              stable_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic              press_r;
    logic              rpt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              rpt_phase_r;
    logic              accept_s;
    logic [31:0]       hold_target_s;
    logic              hold_done_s;

    // Level change acceptance and repeat-interval comparison
    always_comb begin
        accept_s = (sync2_r != stable_r) && (db_cnt_r == DB_LAST);
        if (rpt_phase_r) begin
            hold_target_s = 32'(REPEAT_PERIOD);
        end else begin
            hold_target_s = 32'(REPEAT_DELAY);
        end
        hold_done_s = (32'(hold_cnt_r) + 32'd1) >= hold_target_s;
    end

    // Synchroniser, debounce counter, stable level and press pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            db_cnt_r <= '0;
            press_r  <= 1'b0;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
            press_r <= accept_s && sync2_r;
            if (sync2_r != stable_r) begin
                if (accept_s) begin
                    stable_r <= sync2_r;
                    db_cnt_r <= '0;
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1);
                end
            end else begin
                db_cnt_r <= '0;
            end
        end
    end

    // Hold timer: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD; release or falling edge resets it
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r  <= '0;
            rpt_phase_r <= 1'b0;
            rpt_r       <= 1'b0;
        end else if (!RPT_ON || !stable_r || accept_s) begin
            hold_cnt_r  <= '0;
            rpt_phase_r <= 1'b0;
            rpt_r       <= 1'b0;
        end else if (hold_done_s) begin
            hold_cnt_r  <= '0;
            rpt_phase_r <= 1'b1;
            rpt_r       <= 1'b1;
        end else begin
            hold_cnt_r  <= hold_cnt_r + HOLD_W'(1);
            rpt_r       <= 1'b0;
        end
    end

    assign press = press_r;
    assign rpt   = rpt_r;

endmodule

// File: rtl/key_cmd_arbiter.sv
// Pushbox button front end: per-key event pending bits arbitrated by fixed priority into a valid/ready command.
module key_cmd_arbiter
    import pushbox_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] key_raw,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic       cmd_drop
);

    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] rpt_s;
    logic [NUM_KEYS-1:0] evt_s;
    logic [NUM_KEYS-1:0] pend_r;
    logic [NUM_KEYS-1:0] pend_next_s;
    logic [NUM_KEYS-1:0] grant_s;
    logic [NUM_KEYS-1:0] clr_s;
    logic [2:0]          grant_idx_s;
    logic                drop_s;
    logic                cmd_drop_r;
    logic                cmd_valid_r;
    cmd_t                cmd_r;
    arb_state_t          state_r;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (k != int'(KEY_RESTART))
        ) u_key (
            .clk    (clk),
            .rst    (rst),
            .key_raw(key_raw[k]),
            .press  (press_s[k]),
            .rpt    (rpt_s[k])
        );
    end

    // Fixed-priority grant, pending-bit update and drop detection
    always_comb begin
        evt_s       = press_s | rpt_s;
        grant_s     = '0;
        grant_idx_s = KEY_RIGHT;
        if (state_r == ARB_IDLE) begin
            if (pend_r[KEY_RESTART]) begin
                grant_idx_s = KEY_RESTART;
            end else if (pend_r[KEY_UP]) begin
                grant_idx_s = KEY_UP;
            end else if (pend_r[KEY_DOWN]) begin
                grant_idx_s = KEY_DOWN;
            end else if (pend_r[KEY_LEFT]) begin
                grant_idx_s = KEY_LEFT;
            end else begin
                grant_idx_s = KEY_RIGHT;
            end
            grant_s = pend_r & (5'b00001 << grant_idx_s);
        end else begin
            grant_s = '0;
        end
        // A restart grant flushes every queued direction along with itself
        if (grant_s[KEY_RESTART]) begin
            clr_s = 5'b11111;
        end else begin
            clr_s = grant_s;
        end
        if (en) begin
            pend_next_s = (pend_r & ~clr_s) | evt_s;
            drop_s      = |(evt_s & pend_r & ~clr_s);
        end else begin
            pend_next_s = '0;
            drop_s      = 1'b0;
        end
    end

    // Pending register and registered drop pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r     <= '0;
            cmd_drop_r <= 1'b0;
        end else begin
            pend_r     <= pend_next_s;
            cmd_drop_r <= drop_s;
        end
    end

    // Command handshake FSM with registered cmd/cmd_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ARB_IDLE;
            cmd_valid_r <= 1'b0;
            cmd_r       <= CMD_NONE;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (|grant_s) begin
                        state_r     <= ARB_VALID;
                        cmd_valid_r <= 1'b1;
                        cmd_r       <= key_to_cmd(grant_idx_s);
                    end else begin
                        cmd_valid_r <= 1'b0;
                        cmd_r       <= CMD_NONE;
                    end
                end
                ARB_VALID: begin
                    if (cmd_ready) begin
                        state_r     <= ARB_IDLE;
                        cmd_valid_r <= 1'b0;
                        cmd_r       <= CMD_NONE;
                    end else begin
                        cmd_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ARB_IDLE;
                    cmd_valid_r <= 1'b0;
                    cmd_r       <= CMD_NONE;
                end
            endcase
        end
    end

    assign cmd_valid = cmd_valid_r;
    assign cmd       = cmd_r;
    assign cmd_drop  = cmd_drop_r;

endmodule

// File: tb/tb_key_cmd_arbiter.sv
// Bench for key_cmd_arbiter: table of single-key holds, hand-written corner sequences, and random
// stimulus, all compared every cycle against an event-level reference model.
module tb_key_cmd_arbiter;

    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] key_raw;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       cmd_drop;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    key_cmd_arbiter #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .key_raw  (key_raw),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .cmd_ready(cmd_ready),
        .cmd_drop (cmd_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: keys as sampled levels, accepted after DC equal synchronised samples;
    // events timed by the age of the press; one pending flag per key; one outstanding command.
    bit [2:0] cmd_of [5] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd5};
    bit [4:0] m_s1, m_s2, m_stable, m_evt, m_pend;
    bit [4:0] m_win [DC];
    int       m_press_edge [5];
    bit       m_busy, m_drop;
    bit [2:0] m_cmd;

    task automatic model_step();
        bit [4:0] clr, nevt;
        int g, age;
        bit all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_evt = '0; m_pend = '0;
            m_busy = 1'b0; m_cmd = 3'd0; m_drop = 1'b0;
            for (int j = 0; j < DC; j++) m_win[j] = '0;
            for (int k = 0; k < 5; k++) m_press_edge[k] = 0;
        end else begin
            g = -1;
            if (!m_busy)
                for (int i = 4; i >= 0; i--)
                    if (m_pend[i] && g < 0) g = i;
            clr = '0;
            if (g >= 0) begin
                clr[g] = 1'b1;
                if (g == 4) clr = 5'b11111;
            end
            if (m_busy) begin
                if (cmd_ready) begin
                    m_busy = 1'b0;
                    m_cmd  = 3'd0;
                end
            end else if (g >= 0) begin
                m_busy = 1'b1;
                m_cmd  = cmd_of[g];
            end
            if (en) begin
                m_drop = |(m_evt & m_pend & ~clr);
                m_pend = (m_pend & ~clr) | m_evt;
            end else begin
                m_drop = 1'b0;
                m_pend = '0;
            end
            for (int j = DC - 1; j > 0; j--) m_win[j] = m_win[j-1];
            m_win[0] = m_s2;
            nevt = '0;
            for (int k = 0; k < 5; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++)
                    if (m_win[j][k] == m_stable[k]) all_diff = 1'b0;
                if (all_diff) begin
                    if (!m_stable[k]) begin
                        nevt[k] = 1'b1;
                        m_press_edge[k] = cyc;
                    end
                    m_stable[k] = ~m_stable[k];
                end else if (m_stable[k] && k != 4) begin
                    age = cyc - m_press_edge[k];
                    if (age == RD || (age > RD && ((age - RD) % RP) == 0)) nevt[k] = 1'b1;
                end
            end
            m_evt = nevt;
            m_s2  = m_s1;
            m_s1  = key_raw;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("model_cmd_valid", cmd_valid, m_busy);
                check("model_cmd", cmd, m_cmd);
                check("model_cmd_drop", cmd_drop, m_drop);
            end
        end
    end

    typedef struct {
        int key;
        int hold;
        int exp_cmd;
        int exp_count;
    } vec_t;

    vec_t tbl [7];

    // Holds one key for 'hold' edges with cmd_ready=1; command i expected at offset 8, then 8+RD+RP*(i-1)
    task automatic run_row(input vec_t v);
        int offs [$];
        int exp_off;
        key_raw[v.key] = 1'b1;
        for (int t = 1; t <= v.hold + 80; t++) begin
            @(negedge clk);
            if (t >= v.hold) key_raw[v.key] = 1'b0;
            if (cmd_valid) begin
                offs.push_back(t);
                check("row_cmd", cmd, v.exp_cmd);
            end
        end
        check("row_count", offs.size(), v.exp_count);
        foreach (offs[i]) begin
            exp_off = (i == 0) ? 8 : 8 + RD + RP * (i - 1);
            check("row_offset", offs[i], exp_off);
        end
    endtask

    initial begin
        int q_off [$];
        int q_cmd [$];
        int drops, vcount, p;
        int probs [6] = '{10, 60, 150, 20, 5, 40};

        rst = 1'b1; en = 1'b1; cmd_ready = 1'b1; key_raw = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        check("reset_valid", cmd_valid, 1'b0);
        check("reset_cmd", cmd, 3'd0);
        check("reset_drop", cmd_drop, 1'b0);

        tbl[0] = '{key: 3, hold: 10, exp_cmd: 1, exp_count: 1};
        tbl[1] = '{key: 4, hold: 60, exp_cmd: 5, exp_count: 1};
        tbl[2] = '{key: 2, hold: 60, exp_cmd: 2, exp_count: 6};
        tbl[3] = '{key: 1, hold: 21, exp_cmd: 3, exp_count: 2};
        tbl[4] = '{key: 1, hold: 20, exp_cmd: 3, exp_count: 1};
        tbl[5] = '{key: 0, hold: 3,  exp_cmd: 0, exp_count: 0};
        tbl[6] = '{key: 0, hold: 4,  exp_cmd: 4, exp_count: 1};
        foreach (tbl[i]) run_row(tbl[i]);

        // Down and left pressed together: down first, left two cycles later
        key_raw = 5'b00110;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (t >= 5) key_raw = '0;
            if (cmd_valid) begin
                q_off.push_back(t);
                q_cmd.push_back(int'(cmd));
            end
        end
        check("pair_count", q_off.size(), 2);
        if (q_off.size() == 2) begin
            check("pair_first_cmd", q_cmd[0], 2);
            check("pair_second_cmd", q_cmd[1], 3);
            check("pair_spacing", q_off[1] - q_off[0], 2);
        end

        // Right held off by cmd_ready=0 while up then restart queue; restart wins and flushes up
        q_cmd.delete();
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            key_raw[0] = (t < 5);
            key_raw[3] = (t >= 12 && t < 17);
            key_raw[4] = (t >= 20 && t < 25);
            cmd_ready  = (t >= 40);
            if (cmd_valid && cmd_ready) q_cmd.push_back(int'(cmd));
        end
        check("restart_count", q_cmd.size(), 2);
        if (q_cmd.size() == 2) begin
            check("restart_first", q_cmd[0], 4);
            check("restart_second", q_cmd[1], 5);
        end

        // Left held through two repeats with cmd_ready=0: second repeat finds its bit set
        drops = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            key_raw[1] = (t < 32);
            cmd_ready  = 1'b0;
            if (cmd_drop) drops++;
        end
        check("drop_count", drops, 1);
        check("held_valid", cmd_valid, 1'b1);
        check("held_cmd", cmd, 3'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", cmd_valid, 1'b0);
        check("midrst_cmd", cmd, 3'd0);

        // Press while disabled never becomes a command
        en = 1'b0;
        cmd_ready = 1'b1;
        vcount = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            key_raw[3] = (t < 10);
            if (cmd_valid) vcount++;
        end
        check("en_off_count", vcount, 0);
        en = 1'b1;

        // Random bouncing keys, ready and enable, one reset in the middle
        for (int seg = 0; seg < 6; seg++) begin
            p = probs[seg];
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                for (int k = 0; k < 5; k++)
                    if ($urandom_range(0, 999) < p) key_raw[k] = ~key_raw[k];
                cmd_ready = ($urandom_range(0, 99) < 60);
                en        = ($urandom_range(0, 99) < 95);
                rst       = (seg == 3 && c == 250);
            end
        end
        rst = 1'b0;
        en = 1'b1;
        key_raw = '0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
